strobe_sequencer: RTL and testbench

STROBE_SEQUENCER -- requirements
Module: strobe_sequencer

---
 rtl/strobe_pkg.sv | 23 ++
 rtl/strobe_prescaler.sv | 32 +++
 rtl/strobe_sequencer.sv | 94 +++++++++
 tb/tb_strobe_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/strobe_pkg.sv
// Shared types for the strobe sequencer: pattern modes and the per-position pattern rule.
package strobe_pkg;

    typedef enum logic [1:0] {
        ONE_HOT  = 2'd0,
        ONE_COLD = 2'd1,
        ALL_ON   = 2'd2,
        ALL_OFF  = 2'd3
    } mode_t;

    // Data bit for a position, given the mode and whether it is the frame-start position.
    function automatic logic pattern_bit(input mode_t m, input logic at_start);
        logic b;
        case (m)
            ONE_HOT:  b = at_start;
            ONE_COLD: b = !at_start;
            ALL_ON:   b = 1'b1;
            default:  b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/strobe_prescaler.sv
// Step prescaler: tick on an enabled clock once every div+1 enabled clocks; div sampled on reload.
module strobe_prescaler #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    // Count down while enabled; reload from div on the ticking clock, freeze when disabled.
    always_comb begin
        count_d = count_q;
        tick    = en && (count_q == '0);
        if (en) begin
            count_d = tick ? div : count_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/strobe_sequencer.sv
// Serial strobe pattern generator for an external shift register of LEN positions.
// Define STROBE_SEQUENCER_PRESCALE_EN to include the div-based step prescaler.
module strobe_sequencer
    import strobe_pkg::*;
#(
    parameter int unsigned LEN   = 6,
    parameter int unsigned DIV_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  mode_t                   mode,
    input  logic [DIV_W-1:0]        div,
    output logic                    d,
    output logic                    sclk_en,
    output logic                    sync,
    output logic [$clog2(LEN)-1:0]  pos
);

    localparam int unsigned POS_W = $clog2(LEN);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(LEN - 1);

    logic step;

`ifdef STROBE_SEQUENCER_PRESCALE_EN
    strobe_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .div  (div),
        .tick (step)
    );
`else
    logic unused_div;
    assign unused_div = ^div;
    assign step       = en;
`endif

    // nxt_q is the position the next step will emit; pos_q is the position last emitted.
    logic [POS_W-1:0] pos_q, pos_d;
    logic [POS_W-1:0] nxt_q, nxt_d;
    logic             d_q, d_d;
    logic             sclk_q, sclk_d;
    logic             sync_q, sync_d;
    mode_t            mode_q, mode_d;
    mode_t            mode_cur;
    logic             at_start;

    // Mode is taken fresh at every frame start and held for the remainder of the frame.
    always_comb begin
        at_start = (nxt_q == '0);
        mode_cur = at_start ? mode : mode_q;
        pos_d    = pos_q;
        nxt_d    = nxt_q;
        d_d      = d_q;
        mode_d   = mode_q;
        sclk_d   = 1'b0;
        sync_d   = 1'b0;
        if (step) begin
            pos_d  = nxt_q;
            d_d    = pattern_bit(mode_cur, at_start);
            mode_d = mode_cur;
            sclk_d = 1'b1;
            sync_d = at_start;
            nxt_d  = (nxt_q == LAST_POS) ? '0 : nxt_q + POS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q  <= '0;
            nxt_q  <= '0;
            d_q    <= 1'b1;
            sclk_q <= 1'b0;
            sync_q <= 1'b0;
            mode_q <= ONE_HOT;
        end else begin
            pos_q  <= pos_d;
            nxt_q  <= nxt_d;
            d_q    <= d_d;
            sclk_q <= sclk_d;
            sync_q <= sync_d;
            mode_q <= mode_d;
        end
    end

    assign pos     = pos_q;
    assign d       = d_q;
    assign sclk_en = sclk_q;
    assign sync    = sync_q;

endmodule

// File: tb/tb_strobe_sequencer.sv
// Randomized and directed bench for strobe_sequencer against a step-count reference model.
module tb_strobe_sequencer;
    import strobe_pkg::*;

    localparam int unsigned LEN   = 6;
    localparam int unsigned DIV_W = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    mode_t                  mode;
    logic [DIV_W-1:0]       div;
    logic                   d;
    logic                   sclk_en;
    logic                   sync;
    logic [$clog2(LEN)-1:0] pos;

    always #5 clk = ~clk;

    strobe_sequencer #(
        .LEN   (LEN),
        .DIV_W (DIV_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .div     (div),
        .d       (d),
        .sclk_en (sclk_en),
        .sync    (sync),
        .pos     (pos)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference: the k-th step since reset emits position k mod LEN; a step comes every div+1 enabled clocks.
    int    m_steps;
    int    m_elapsed;
    int    m_period;
    mode_t m_mode;
    int    exp_pos, exp_d, exp_sclk, exp_sync;

    function automatic int pat(input mode_t m, input int p);
        case (m)
            ONE_HOT:  return (p == 0) ? 1 : 0;
            ONE_COLD: return (p != 0) ? 1 : 0;
            ALL_ON:   return 1;
            default:  return 0;
        endcase
    endfunction

    task automatic model(input logic r, input logic e, input mode_t md, input int dv);
        bit take;
        int p;
        if (r) begin
            m_steps = 0; m_elapsed = 0; m_period = 1; m_mode = ONE_HOT;
            exp_pos = 0; exp_d = 1; exp_sclk = 0; exp_sync = 0;
        end else begin
            exp_sclk = 0;
            exp_sync = 0;
            if (e) begin
`ifdef STROBE_SEQUENCER_PRESCALE_EN
                take = (m_elapsed + 1 >= m_period);
`else
                take = 1'b1;
`endif
                if (take) begin
                    p = m_steps % LEN;
                    if (p == 0) m_mode = md;
                    exp_pos  = p;
                    exp_d    = pat(m_mode, p);
                    exp_sync = (p == 0) ? 1 : 0;
                    exp_sclk = 1;
                    m_steps++;
                    m_elapsed = 0;
                    m_period  = dv + 1;
                end else begin
                    m_elapsed++;
                end
            end
        end
    endtask

    task automatic cyc(input string tag, input logic r, input logic e, input mode_t md, input int dv);
        @(negedge clk);
        rst  = r;
        en   = e;
        mode = md;
        div  = DIV_W'(dv);
        @(posedge clk);
        model(r, e, md, dv);
        #1;
        check({tag, ".pos"},     int'(pos),     exp_pos);
        check({tag, ".d"},       int'(d),       exp_d);
        check({tag, ".sclk_en"}, int'(sclk_en), exp_sclk);
        check({tag, ".sync"},    int'(sync),    exp_sync);
    endtask

    // Run enabled until the model emits the target position; an exhausted budget is a failure.
    task automatic run_until(input string tag, input int target, input mode_t md, input int dv);
        int found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            cyc(tag, 1'b0, 1'b1, md, dv);
            if (exp_sclk == 1 && exp_pos == target) found = 1;
        end
        check({tag, ".reached"}, found, 1);
    endtask

    initial begin
        mode_t rmode;
        logic  rrst, ren;
        int    rdiv;
        rst = 1'b1; en = 1'b0; mode = ONE_HOT; div = '0;

        for (int i = 0; i < 3; i++) cyc("reset", 1'b1, 1'b1, ALL_OFF, 0);

        for (int i = 0; i < 18; i++) cyc("onehot_div0", 1'b0, 1'b1, ONE_HOT, 0);

        for (int i = 0; i < 18; i++) cyc("div2", 1'b0, 1'b1, ONE_HOT, 2);

        run_until("mode_wait", 3, ONE_HOT, 0);
        for (int i = 0; i < 14; i++) cyc("mode_switch", 1'b0, 1'b1, ONE_COLD, 0);

        run_until("en_wait", 2, ONE_HOT, 1);
        for (int i = 0; i < 5; i++) cyc("en_low", 1'b0, 1'b0, ONE_HOT, 1);
        for (int i = 0; i < 6; i++) cyc("en_resume", 1'b0, 1'b1, ONE_HOT, 1);

        run_until("rst_wait", 4, ONE_HOT, 0);
        for (int i = 0; i < 2; i++) cyc("mid_rst", 1'b1, 1'b1, ONE_HOT, 0);
        for (int i = 0; i < 8; i++) cyc("post_rst", 1'b0, 1'b1, ONE_HOT, 0);

        for (int i = 0; i < 8; i++) cyc("div5", 1'b0, 1'b1, ALL_ON, 5);

        rmode = ONE_HOT;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) rmode = mode_t'($urandom_range(0, 3));
            rrst = ($urandom_range(0, 63) == 0);
            ren  = ($urandom_range(0, 4) != 0);
            rdiv = $urandom_range(0, 3);
            cyc("random", rrst, ren, rmode, rdiv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
